// File: rtl/bus_phase_sched_pkg.sv
// Shared state encoding, default timing constants and counter-width helpers for the bus phase scheduler.
package bus_phase_sched_pkg;

  localparam int HALF_FAST_DEF   = 4;
  localparam int HALF_SLOW_DEF   = 8;
  localparam int MAX_STRETCH_DEF = 32;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_STRETCH = 2'd1;
  localparam logic [1:0] ST_HALTED  = 2'd2;

  function automatic int cnt_w(input int half_slow);
    return $clog2(2 * half_slow);
  endfunction

  function automatic int scnt_w(input int max_stretch);
    return (max_stretch > 1) ? $clog2(max_stretch) : 1;
  endfunction

endpackage

// File: rtl/bus_phase_sched_fdc_clk_gate.sv
// Gated half-rate FDC clock; enable is only looked at while the clock is low, so a stop always
// finishes the high phase and parks low. fdc_ce_o flags the clock before each rising edge.
module fdc_clk_gate (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic fdc_clk_o,
  output logic fdc_ce_o
);

  logic fdc_clk_q;
  logic fdc_clk_d;

  assign fdc_clk_d = ~fdc_clk_q & en_i;
  assign fdc_ce_o  = ~fdc_clk_q & en_i & ~rst_i;
  assign fdc_clk_o = fdc_clk_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fdc_clk_q <= 1'b0;
    end else begin
      fdc_clk_q <= fdc_clk_d;
    end
  end

endmodule

// File: rtl/bus_phase_sched.sv
// Bus phase sequencer: phi_0 with phase enables, phi2 wait-state stretching with timeout, halt at
// cycle boundaries, plus the gated FDC clock. Phase outputs are registered; cycle_end_ce follows inputs.
module bus_phase_sched
  import bus_phase_sched_pkg::*;
#(
  parameter int HALF_FAST   = HALF_FAST_DEF,
  parameter int HALF_SLOW   = HALF_SLOW_DEF,
  parameter int MAX_STRETCH = MAX_STRETCH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic slow_sel,
  input  logic stretch_req,
  input  logic halt_req,
  input  logic fdc_en,
  input  logic timeout_clr,
  output logic phi_0,
  output logic phi1_ce,
  output logic phi2_ce,
  output logic cycle_end_ce,
  output logic stretching,
  output logic stretch_timeout,
  output logic halted,
  output logic fdc_clk,
  output logic fdc_ce
);

  localparam int CNT_W  = cnt_w(HALF_SLOW);
  localparam int SCNT_W = scnt_w(MAX_STRETCH);

  localparam logic [CNT_W-1:0]  END_FAST  = CNT_W'(2 * HALF_FAST - 1);
  localparam logic [CNT_W-1:0]  END_SLOW  = CNT_W'(2 * HALF_SLOW - 1);
  localparam logic [CNT_W-1:0]  MID_FAST  = CNT_W'(HALF_FAST);
  localparam logic [CNT_W-1:0]  MID_SLOW  = CNT_W'(HALF_SLOW);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(MAX_STRETCH - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              slow_q, slow_d;
  logic              start_q;
  logic              phi_0_q, phi1_ce_q, phi2_ce_q, stretching_q, halted_q, timeout_q;
  logic [CNT_W-1:0]  end_cnt, mid_d;
  logic              cyc_end, to_set;

  assign end_cnt = slow_q ? END_SLOW : END_FAST;
  assign mid_d   = slow_d ? MID_SLOW : MID_FAST;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    slow_d  = slow_q;
    cyc_end = 1'b0;
    to_set  = 1'b0;
    // start_q marks the pre-run clock after reset so cnt=0 appears with phi1_ce on release.
    if (start_q) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (cnt_q == end_cnt) begin
            if (stretch_req) begin
              state_d = ST_STRETCH;
              scnt_d  = '0;
            end else begin
              cyc_end = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STRETCH: begin
          if (stretch_req && (scnt_q != SCNT_LAST)) begin
            scnt_d = scnt_q + SCNT_W'(1);
          end else begin
            cyc_end = 1'b1;
            to_set  = stretch_req;
          end
        end
        ST_HALTED: begin
          if (!halt_req) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
      if (cyc_end) begin
        slow_d  = slow_sel;
        cnt_d   = '0;
        state_d = halt_req ? ST_HALTED : ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      scnt_q       <= '0;
      slow_q       <= 1'b0;
      start_q      <= 1'b1;
      phi_0_q      <= 1'b0;
      phi1_ce_q    <= 1'b0;
      phi2_ce_q    <= 1'b0;
      stretching_q <= 1'b0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scnt_q       <= scnt_d;
      slow_q       <= slow_d;
      start_q      <= 1'b0;
      phi_0_q      <= (state_d == ST_STRETCH) || ((state_d == ST_RUN) && (cnt_d >= mid_d));
      phi1_ce_q    <= (state_d == ST_RUN) && (cnt_d == '0);
      phi2_ce_q    <= (state_d == ST_RUN) && (cnt_d == mid_d);
      stretching_q <= (state_d == ST_STRETCH);
      halted_q     <= (state_d == ST_HALTED);
      if (to_set) begin
        timeout_q <= 1'b1;
      end else if (timeout_clr) begin
        timeout_q <= 1'b0;
      end
    end
  end

  assign phi_0           = phi_0_q;
  assign phi1_ce         = phi1_ce_q;
  assign phi2_ce         = phi2_ce_q;
  assign cycle_end_ce    = cyc_end & ~rst;
  assign stretching      = stretching_q;
  assign stretch_timeout = timeout_q;
  assign halted          = halted_q;

  fdc_clk_gate u_fdc_clk_gate (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (fdc_en),
    .fdc_clk_o (fdc_clk),
    .fdc_ce_o  (fdc_ce)
  );

endmodule

// File: tb/tb_bus_phase_sched.sv
// Directed bench for bus_phase_sched: cycle lengths, stretch/timeout, speed change, halt, FDC gating, reset.
module tb_bus_phase_sched;

  logic clk = 1'b0;
  logic rst, slow_sel, stretch_req, halt_req, fdc_en, timeout_clr;
  logic phi_0, phi1_ce, phi2_ce, cycle_end_ce, stretching, stretch_timeout, halted, fdc_clk, fdc_ce;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_phase_sched dut (
    .clk             (clk),
    .rst             (rst),
    .slow_sel        (slow_sel),
    .stretch_req     (stretch_req),
    .halt_req        (halt_req),
    .fdc_en          (fdc_en),
    .timeout_clr     (timeout_clr),
    .phi_0           (phi_0),
    .phi1_ce         (phi1_ce),
    .phi2_ce         (phi2_ce),
    .cycle_end_ce    (cycle_end_ce),
    .stretching      (stretching),
    .stretch_timeout (stretch_timeout),
    .halted          (halted),
    .fdc_clk         (fdc_clk),
    .fdc_ce          (fdc_ce)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one bus cycle from its phi1_ce clock, applying per-clock stimulus at the given cycle indices.
  task automatic run_cycle(input int st_at, input int st_len, input int sl_at, input int sl_val,
                           input int h_at, input int clr,
                           output int len, output int hi, output int str_n, output int p2i);
    int  n;
    bit  done;
    n = 0;
    while (phi1_ce !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check("sync_phi1", phi1_ce, 1);
    len = 0; hi = 0; str_n = 0; p2i = -1; done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      stretch_req = (k >= st_at) && (k < st_at + st_len);
      if (k == sl_at) slow_sel = sl_val[0];
      if (k == h_at) halt_req = 1'b1;
      timeout_clr = clr[0];
      #1;
      if (phi_0 === 1'b1) hi++;
      if (stretching === 1'b1) str_n++;
      if (phi2_ce === 1'b1 && p2i < 0) p2i = k;
      if (cycle_end_ce === 1'b1) begin
        len  = k + 1;
        done = 1'b1;
      end else begin
        tick();
      end
    end
    check("cycle_done", done, 1);
    tick();
    stretch_req = 1'b0;
    timeout_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int   len, hi, sn, p2, n;
    logic prev;
    rst = 1'b1; slow_sel = 1'b0; stretch_req = 1'b0; halt_req = 1'b0;
    fdc_en = 1'b1; timeout_clr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_phi0", phi_0, 0);
    check("rst_phi1ce", phi1_ce, 0);
    check("rst_phi2ce", phi2_ce, 0);
    check("rst_cend", cycle_end_ce, 0);
    check("rst_stretching", stretching, 0);
    check("rst_timeout", stretch_timeout, 0);
    check("rst_halted", halted, 0);
    check("rst_fdcclk", fdc_clk, 0);
    check("rst_fdcce", fdc_ce, 0);

    rst = 1'b0;
    tick();
    check("rel_phi1ce", phi1_ce, 1);
    check("rel_phi0", phi_0, 0);
    prev = fdc_clk;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("fdc_toggle", fdc_clk, !prev);
      check("fdc_ce_run", fdc_ce, !fdc_clk);
      prev = fdc_clk;
    end

    // fast cycle
    run_cycle(-1, 0, -1, 0, -1, 0, len, hi, sn, p2);
    check("fast_len", len, 8);
    check("fast_hi", hi, 4);
    check("fast_p2", p2, 4);
    check("fast_str", sn, 0);

    // short stretch
    run_cycle(7, 3, -1, 0, -1, 0, len, hi, sn, p2);
    check("st3_len", len, 11);
    check("st3_hi", hi, 7);
    check("st3_str", sn, 3);
    check("st3_timeout", stretch_timeout, 0);

    // capped stretch with timeout
    run_cycle(7, 40, -1, 0, -1, 0, len, hi, sn, p2);
    check("st40_len", len, 40);
    check("st40_hi", hi, 36);
    check("st40_str", sn, 32);
    check("st40_timeout", stretch_timeout, 1);
    run_cycle(-1, 0, -1, 0, -1, 0, len, hi, sn, p2);
    check("after_st_len", len, 8);
    check("timeout_sticky", stretch_timeout, 1);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    check("timeout_clr", stretch_timeout, 0);
    run_cycle(7, 40, -1, 0, -1, 1, len, hi, sn, p2);
    check("setclr_len", len, 40);
    check("set_wins", stretch_timeout, 1);

    // speed change
    run_cycle(-1, 0, 2, 1, -1, 0, len, hi, sn, p2);
    check("sl_up_cur_len", len, 8);
    check("sl_up_cur_hi", hi, 4);
    run_cycle(-1, 0, -1, 0, -1, 0, len, hi, sn, p2);
    check("slow_len", len, 16);
    check("slow_hi", hi, 8);
    check("slow_p2", p2, 8);
    run_cycle(-1, 0, 5, 0, -1, 0, len, hi, sn, p2);
    check("sl_dn_cur_len", len, 16);
    run_cycle(-1, 0, -1, 0, -1, 0, len, hi, sn, p2);
    check("fast_again_len", len, 8);
    check("fast_again_hi", hi, 4);

    // halt
    run_cycle(-1, 0, -1, 0, 3, 0, len, hi, sn, p2);
    check("halt_cyc_len", len, 8);
    check("halted_set", halted, 1);
    check("halted_phi0", phi_0, 0);
    check("halted_phi1ce", phi1_ce, 0);
    prev = fdc_clk;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("halted_hold", halted, 1);
      check("halted_fdc_toggle", fdc_clk, !prev);
      prev = fdc_clk;
    end
    halt_req = 1'b0;
    tick();
    check("unhalt_phi1ce", phi1_ce, 1);
    check("unhalt_halted", halted, 0);
    run_cycle(-1, 0, -1, 0, -1, 0, len, hi, sn, p2);
    check("unhalt_len", len, 8);

    // FDC stop while high
    n = 0;
    while (fdc_clk !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    check("fdc_high_found", fdc_clk, 1);
    fdc_en = 1'b0;
    #1;
    check("fdc_stop_ce", fdc_ce, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fdc_parked", fdc_clk, 0);
      check("fdc_parked_ce", fdc_ce, 0);
    end
    fdc_en = 1'b1;
    #1;
    check("fdc_restart_ce", fdc_ce, 1);
    tick();
    check("fdc_restart_clk", fdc_clk, 1);

    // reset during stretch
    n = 0;
    while (phi1_ce !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check("sync_rst", phi1_ce, 1);
    repeat (7) tick();
    stretch_req = 1'b1;
    tick();
    tick();
    check("mid_stretch", stretching, 1);
    rst = 1'b1;
    tick();
    check("rs_phi0", phi_0, 0);
    check("rs_stretching", stretching, 0);
    check("rs_phi1ce", phi1_ce, 0);
    check("rs_phi2ce", phi2_ce, 0);
    check("rs_cend", cycle_end_ce, 0);
    check("rs_timeout", stretch_timeout, 0);
    check("rs_halted", halted, 0);
    check("rs_fdcclk", fdc_clk, 0);
    check("rs_fdcce", fdc_ce, 0);
    stretch_req = 1'b0;
    rst = 1'b0;
    tick();
    check("rs_rel_phi1ce", phi1_ce, 1);
    check("rs_rel_stretching", stretching, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
